cross_bar_nxm: RTL
==================

// Module: cross_bar_nxm
// PURPOSE
//  Parametrised N-master x M-slave crossbar for the req/ack/resp bus (master holds req/addr/cmd/wdata until ack;
//  slave returns resp+rdata on the clock after ack). Decodes the slave from upper address bits. Each slave port
//  has its own round-robin arbiter, so transfers to different slaves run concurrently.
//  Sits between the CPU/DMA masters and the peripheral slaves.
// PARAMETERS
//  N_MASTERS  2   number of master ports (1..16)
//  N_SLAVES   4   number of slave ports (1..16)
//  AWIDTH     32  address width
//  DWIDTH     32  data width
//  SEL_W      2   address MSBs used as slave index: sel = addr[AWIDTH-1 -: SEL_W]; 2**SEL_W >= N_SLAVES
// PORTS
//  aclk     in   1                   clock, all logic on rising edge
//  areset   in   1                   asynchronous, active-high reset
//  m_req    in   N_MASTERS           per-master request
//  m_addr   in   N_MASTERS*AWIDTH    per-master address, master i at [i*AWIDTH +: AWIDTH]
//  m_cmd    in   N_MASTERS           0 read, 1 write
//  m_wdata  in   N_MASTERS*DWIDTH    per-master write data
//  m_ack    out  N_MASTERS           request accepted
//  m_rdata  out  N_MASTERS*DWIDTH    read data, valid with m_resp
//  m_resp   out  N_MASTERS           response strobe
//  s_req    out  N_SLAVES            per-slave request
//  s_addr   out  N_SLAVES*AWIDTH     full, unmodified master address
//  s_cmd    out  N_SLAVES            command
//  s_wdata  out  N_SLAVES*DWIDTH     write data
//  s_ack    in   N_SLAVES            slave ack
//  s_rdata  in   N_SLAVES*DWIDTH     slave read data
//  s_resp   in   N_SLAVES            slave response strobe
// BEHAVIOUR
//  - Reset: all FSMs IDLE; all RR pointers 0; m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd and s_wdata all 0.
//  - Per-slave FSM states: IDLE, GRANT, RESP.
//  - IDLE:
//    - Candidates are masters with m_req=1 whose sel equals this slave.
//    - The winner is the first candidate at or after ptr, searching upward and wrapping mod N_MASTERS.
//    - The grant index is registered and the FSM goes to GRANT; with no candidates it stays IDLE.
//  - GRANT:
//    - s_req/s_addr/s_cmd/s_wdata = the granted master's live signals (combinational mux from the grant register).
//    - m_ack[g] = s_ack, combinational. Non-granted masters see m_ack=0.
//    - On s_ack=1: go to RESP.
//    - If m_req[g] drops before ack (protocol violation): s_req falls the same cycle; the FSM goes to IDLE with no resp.
//  - RESP:
//    - s_req=0. m_resp[g]=s_resp and m_rdata[g]=s_rdata, combinational; other masters' rdata are 0.
//    - Next state is IDLE and ptr=g+1 (wraps to 0 after N_MASTERS-1), whether or not s_resp was seen.
//  - Latency: m_req -> s_req 1 clk; s_ack -> m_ack 0 clk; s_resp -> m_resp 0 clk.
//  - Minimum 3 clk per transfer per slave; the idle cycle after RESP is mandatory.
//  - A master targets one slave at a time, so no master is ever granted by two slaves.
//  - Different slaves serve different masters in the same cycle with no interaction.
//  - Unmapped sel (>= N_SLAVES): no slave arbiter sees the request (see CONFIGURATION).
//  - areset mid-transfer: immediate return to reset values, in-flight transfer dropped; ptr reset to 0.
// CONFIGURATION
//  CROSS_BAR_DECERR_EN defined:
//    - An internal default slave serves unmapped sel using the same FSM and RR arbitration.
//    - It acks in GRANT on the first cycle.
//    - Next cycle m_resp=1, m_rdata={DWIDTH{1'b1}}, and extra output m_decerr[N_MASTERS]=1 for that master for 1 clk.
//  CROSS_BAR_DECERR_EN undefined:
//    - No default slave and no m_decerr port.
//    - An unmapped request is never acked; the master stalls until it drops req.
// TESTING
//  1. Single write:
//     - Stimulus: M0 addr=0x4000_0010, cmd=1, wdata=0xA5A5_0001.
//     - Response: s_req[1] one clk later with the same addr/wdata; slave ack -> m_ack[0] the same cycle; s_resp -> m_resp[0].
//  2. Contention, 2 masters -> slave 2 (addr 0x8000_0000), both req in cycle 0:
//     - M0 granted first (ptr=0), then M1.
//     - Repeat with both requesting again: order M0, M1 again, since ptr returns to 0 after M1.
//  3. Concurrency:
//     - Stimulus: M0 -> slave 0, M1 -> slave 3, same cycle.
//     - Response: s_req[0] and s_req[3] rise in the same clk; both m_resp return independently.
//  4. Read data routing:
//     - Stimulus: M1 reads slave 1; slave returns rdata=0xDEAD_0042.
//     - Response: m_rdata[1]=0xDEAD_0042 with m_resp[1]; m_resp[0]=0 and m_rdata[0]=0.
//  5. Reset during GRANT:
//     - Stimulus: pulse areset while s_req[2]=1.
//     - Response: s_req[2]=0 immediately; no m_ack; new requests after release start from ptr 0.
//  6. Unmapped address (N_SLAVES=3, sel=3):
//     - With _EN: m_ack, then m_resp with rdata=0xFFFF_FFFF and m_decerr=1.
//     - Without _EN: no ack for 20 clks, no s_req activity.

Source files
------------

// File: rtl/cross_bar_nxm.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_nxm
// Brief    : N-master x M-slave req/ack/resp crossbar, one round-robin arbiter
//            per slave. Define CROSS_BAR_DECERR_EN to add a default slave that
//            error-terminates unmapped addresses (adds the m_decerr port).
// Revision : 1.0
// ============================================================================
module cross_bar_nxm #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 4,
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int SEL_W     = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*AWIDTH-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_cmd,
    input  logic [N_MASTERS*DWIDTH-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS*DWIDTH-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_resp,
`ifdef CROSS_BAR_DECERR_EN
    output logic [N_MASTERS-1:0]          m_decerr,
`endif
    output logic [N_SLAVES-1:0]           s_req,
    output logic [N_SLAVES*AWIDTH-1:0]    s_addr,
    output logic [N_SLAVES-1:0]           s_cmd,
    output logic [N_SLAVES*DWIDTH-1:0]    s_wdata,
    input  logic [N_SLAVES-1:0]           s_ack,
    input  logic [N_SLAVES*DWIDTH-1:0]    s_rdata,
    input  logic [N_SLAVES-1:0]           s_resp
);

`ifdef CROSS_BAR_DECERR_EN
    localparam int N_ARB = N_SLAVES + 1;
`else
    localparam int N_ARB = N_SLAVES;
`endif
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    logic [SEL_W-1:0]  w_sel      [N_MASTERS];
    logic [N_ARB-1:0]  w_in_grant;
    logic [N_ARB-1:0]  w_in_resp;
    logic [N_ARB-1:0]  w_sl_ack;
    logic [N_ARB-1:0]  w_sl_resp;
    logic [MW-1:0]     w_grant    [N_ARB];
    logic [DWIDTH-1:0] w_sl_rdata [N_ARB];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_sel
        assign w_sel[i] = m_addr[i*AWIDTH + AWIDTH-1 -: SEL_W];
    end

    // Arbiter index N_SLAVES (present only with the default slave) owns unmapped selects.
    for (genvar a = 0; a < N_ARB; a++) begin : g_arb
        state_t               r_state;
        state_t               w_state_nxt;
        logic [MW-1:0]        r_grant;
        logic [MW-1:0]        w_grant_nxt;
        logic [MW-1:0]        r_ptr;
        logic [MW-1:0]        w_ptr_nxt;
        logic [N_MASTERS-1:0] w_cand;
        logic                 w_found;
        logic [MW-1:0]        w_win;
        int                   w_idx;

        always_comb begin
            w_cand = '0;
            for (int i = 0; i < N_MASTERS; i++) begin
                if (a < N_SLAVES)
                    w_cand[i] = m_req[i] && (int'(w_sel[i]) == a);
                else
                    w_cand[i] = m_req[i] && (int'(w_sel[i]) >= N_SLAVES);
            end
        end

        // Scan downward so the last hit is the first candidate at or after ptr.
        always_comb begin
            w_found = 1'b0;
            w_win   = '0;
            w_idx   = 0;
            for (int k = N_MASTERS-1; k >= 0; k--) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N_MASTERS)
                    w_idx = w_idx - N_MASTERS;
                if (w_cand[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = MW'(w_idx);
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_grant_nxt = r_grant;
            w_ptr_nxt   = r_ptr;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_state_nxt = ST_GRANT;
                        w_grant_nxt = w_win;
                    end
                end
                ST_GRANT: begin
                    if (!m_req[r_grant])
                        w_state_nxt = ST_IDLE;
                    else if (w_sl_ack[a])
                        w_state_nxt = ST_RESP;
                end
                ST_RESP: begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (int'(r_grant) == N_MASTERS-1) ? '0 : r_grant + 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_ptr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_grant <= w_grant_nxt;
                r_ptr   <= w_ptr_nxt;
            end
        end

        assign w_in_grant[a] = (r_state == ST_GRANT);
        assign w_in_resp[a]  = (r_state == ST_RESP);
        assign w_grant[a]    = r_grant;

        if (a < N_SLAVES) begin : g_slave
            assign w_sl_ack[a]   = s_ack[a];
            assign w_sl_resp[a]  = s_resp[a];
            assign w_sl_rdata[a] = s_rdata[a*DWIDTH +: DWIDTH];
            assign s_req[a]      = w_in_grant[a] & m_req[r_grant];
            assign s_cmd[a]      = w_in_grant[a] & m_cmd[r_grant];
            assign s_addr[a*AWIDTH +: AWIDTH]  = w_in_grant[a] ? m_addr[r_grant*AWIDTH +: AWIDTH]  : '0;
            assign s_wdata[a*DWIDTH +: DWIDTH] = w_in_grant[a] ? m_wdata[r_grant*DWIDTH +: DWIDTH] : '0;
        end else begin : g_default
            // Default slave: acks at once, then answers with all-ones data.
            assign w_sl_ack[a]   = 1'b1;
            assign w_sl_resp[a]  = 1'b1;
            assign w_sl_rdata[a] = '1;
        end
    end

    // A master targets one slave at a time, so at most one arbiter drives each master.
    always_comb begin
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
`ifdef CROSS_BAR_DECERR_EN
        m_decerr = '0;
`endif
        for (int a = 0; a < N_ARB; a++) begin
            if (w_in_grant[a] && w_sl_ack[a])
                m_ack[w_grant[a]] = 1'b1;
            if (w_in_resp[a]) begin
                m_resp[w_grant[a]] = w_sl_resp[a];
                m_rdata[w_grant[a]*DWIDTH +: DWIDTH] = w_sl_rdata[a];
`ifdef CROSS_BAR_DECERR_EN
                if (a >= N_SLAVES)
                    m_decerr[w_grant[a]] = 1'b1;
`endif
            end
        end
    end

endmodule
`default_nettype wire
